fir_mac_sequencer: RTL
======================

# fir_mac_sequencer

Control sequencer for the time-multiplexed FIR datapath: one multiply-accumulate unit shared across all taps, with coefficients selected by `current_count` and samples held in a circular delay-line RAM. Per accepted input sample it:
- writes the sample into the ring,
- sweeps `current_count` over every tap, addressing the matching delayed sample,
- drives MAC clear/accumulate,
- waits out the MAC pipeline and presents a result-valid handshake.

It sits between the sample source, the sample RAM, the coefficient selector and the MAC.

## Interface
Parameters:
- `NUMBER_OF_TAPS`, 64: taps per output; must be ≥ 2; need not be a power of two.
- `MAC_LATENCY`, 2: cycles from the last `acc_en` to the accumulator holding the final sum; range 0–15.
- `COUNTER_BITS`, derived localparam: `$clog2(NUMBER_OF_TAPS)`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  source offers a sample.
- `in_ready`  out  1  sequencer accepts a sample (IDLE only).
- `wr_en`  out  1  sample RAM write strobe.
- `wr_zero`  out  1  RAM write data is forced to 0 (clear phase).
- `wr_addr`  out  COUNTER_BITS  RAM write address.
- `rd_addr`  out  COUNTER_BITS  RAM read address of the delayed sample for the current tap.
- `current_count`  out  COUNTER_BITS  tap index to the coefficient selector.
- `acc_clear`  out  1  MAC loads the product instead of adding (first tap).
- `acc_en`  out  1  MAC consumes the product this cycle.
- `out_valid`  out  1  accumulator holds a finished output.
- `out_ready`  in  1  downstream takes the output.
- `busy`  out  1  high in every state except IDLE.

## Operation
States: CLEAR → IDLE → RUN → DRAIN → DONE → IDLE.

- **CLEAR** (entered on reset)
  - Each cycle: `wr_en=1`, `wr_zero=1`, `wr_addr` = clear counter, counting 0..N-1.
  - After slot N-1: `head` ← N-1, go to IDLE.
  - `in_ready=0` throughout.
- **IDLE**
  - `in_ready=1`.
  - Handshake when `in_valid & in_ready`. That same cycle: `wr_en=1`, `wr_zero=0`, `wr_addr=next(head)`.
  - At the edge: `head` ← `next(head)`, count ← 0, go to RUN.
  - `next(h)` is `h+1`, wrapping N-1 → 0 by explicit compare, never by bit truncation.
- **RUN**, count k = 0..N-1, one tap per cycle:
  - `current_count=k`, `acc_en=1`, `acc_clear=(k==0)`.
  - `rd_addr = (head ≥ k) ? head−k : head+N−k`, i.e. tap k pairs `coeff[k]` with `x[n−k]`.
  - After k=N-1: go to DRAIN, or to DONE if `MAC_LATENCY`=0.
- **DRAIN**
  - Counts `MAC_LATENCY` cycles with `acc_en=0`, then DONE.
- **DONE**
  - `out_valid=1`, held until `out_ready`.
  - On `out_valid & out_ready`: go to IDLE.
  - No sample is accepted in DONE.

Rules:
- `in_valid` in any non-IDLE state is ignored. It has no side effect and is not latched.
- `current_count` and `rd_addr` outside RUN: hold 0 and `head`; the consumer ignores them.
- Reset mid-operation (any state): next cycle is CLEAR. The partial result is discarded, `out_valid` drops, and the ring is re-zeroed.
- No simultaneous write and read of the same RAM address can occur: writes happen only in IDLE/CLEAR, reads only in RUN.

## Timing
- Reset values (cycle after `rst` high):
  - state CLEAR, clear counter 0, `head` = N-1, count 0.
  - `in_ready=0`, `wr_en=1`, `wr_zero=1`, `wr_addr=0`.
  - `acc_en=0`, `acc_clear=0`, `out_valid=0`, `busy=1`.
- Clear phase: N cycles; `in_ready` rises in cycle N after reset deasserts.
- Accept at cycle 0 → RUN in cycles 1..N → DRAIN in cycles N+1..N+`MAC_LATENCY` → `out_valid` first high in cycle N+`MAC_LATENCY`+1.
- With `out_ready` held high: `in_ready` is high again 1 cycle after `out_valid`; period per sample is N+`MAC_LATENCY`+2.
- RAM read latency is absorbed by the MAC pipeline and is counted inside `MAC_LATENCY`.
- All state, counters and `head` are registered. Outputs are decoded from state/counters only, plus `in_valid` gating for `wr_en`; no input→output paths other than that.

## Structure
- Shared package `fir_pkg` holds:
  - `seq_state_t` enum {CLEAR, IDLE, RUN, DRAIN, DONE};
  - a `ring_next`/`ring_sub` modulo-N helper function pair, used by this block and testbench models.
- One sub-module, `fir_ring_addr`: combinational, computing `rd_addr` from `head` and count with modulo-N wrap. It is reused by the RAM model in the bench.

## Test plan
- Reset, then idle, N=64 → `wr_en`/`wr_zero` high for 64 cycles, `wr_addr` 0..63; `in_ready` rises in cycle 64.
- Single sample, N=4, `MAC_LATENCY`=2 → `wr_addr=0`; RUN `rd_addr` 0,3,2,1 with `current_count` 0..3 and `acc_clear` only at k=0; `out_valid` in cycle 7.
- Non-power-of-two wrap, N=5, 7 samples → write addresses 0,1,2,3,4,0,1; on the 7th sample `rd_addr` sequence 1,0,4,3,2.
- Backpressure: `out_ready` low 10 cycles in DONE → `out_valid` stays high, `in_ready` stays low, and `in_valid` pulses cause no write; `out_ready` high → IDLE next cycle.
- `rst` asserted at RUN count 2 → next cycle CLEAR with `out_valid=0`; full N-cycle re-zero follows.
- Back-to-back samples with `in_valid` and `out_ready` tied high, N=8, `MAC_LATENCY`=2 → accepts spaced exactly 12 cycles apart.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and modulo-N ring helpers for the time-multiplexed FIR
// sequencer and its models.
package fir_pkg;

  typedef enum logic [2:0] {CLEAR, IDLE, RUN, DRAIN, DONE} seq_state_t;

  // Wrap is an explicit compare so N need not be a power of two.
  function automatic int ring_next(input int h, input int n);
    return (h == n - 1) ? 0 : h + 1;
  endfunction

  function automatic int ring_sub(input int h, input int k, input int n);
    return (h >= k) ? h - k : h + n - k;
  endfunction

endpackage

// File: rtl/fir_ring_addr.sv
// Delay-line read address: the sample written k accepts before the one at
// head, wrapped modulo NUMBER_OF_TAPS.
module fir_ring_addr
  import fir_pkg::*;
#(
  parameter  int NUMBER_OF_TAPS = 64,
  localparam int COUNTER_BITS   = $clog2(NUMBER_OF_TAPS)
) (
  input  logic [COUNTER_BITS-1:0] head,
  input  logic [COUNTER_BITS-1:0] count,
  output logic [COUNTER_BITS-1:0] addr
);

  assign addr = COUNTER_BITS'(ring_sub(int'(head), int'(count), NUMBER_OF_TAPS));

endmodule

// File: rtl/fir_mac_sequencer.sv
// Control sequencer for a single shared MAC sweeping all FIR taps over a
// circular sample RAM: clear ring, accept sample, sweep taps, drain, present.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter  int NUMBER_OF_TAPS = 64,
  parameter  int MAC_LATENCY    = 2,
  localparam int COUNTER_BITS   = $clog2(NUMBER_OF_TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    wr_en,
  output logic                    wr_zero,
  output logic [COUNTER_BITS-1:0] wr_addr,
  output logic [COUNTER_BITS-1:0] rd_addr,
  output logic [COUNTER_BITS-1:0] current_count,
  output logic                    acc_clear,
  output logic                    acc_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam logic [COUNTER_BITS-1:0] LAST     = COUNTER_BITS'(NUMBER_OF_TAPS - 1);
  localparam logic [3:0]              LAT_LAST = 4'((MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0);

  seq_state_t              state, state_n;
  logic [COUNTER_BITS-1:0] cnt, cnt_n;
  logic [COUNTER_BITS-1:0] head, head_n, head_inc;
  logic [COUNTER_BITS-1:0] tap;
  logic [3:0]              lat, lat_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      head  <= LAST;
      lat   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      head  <= head_n;
      lat   <= lat_n;
    end
  end

  assign head_inc = COUNTER_BITS'(ring_next(int'(head), NUMBER_OF_TAPS));

  // Outside RUN the tap is forced to 0 so rd_addr rests on head.
  assign tap = (state == RUN) ? cnt : '0;

  fir_ring_addr #(.NUMBER_OF_TAPS(NUMBER_OF_TAPS)) u_ring_addr (
    .head  (head),
    .count (tap),
    .addr  (rd_addr)
  );

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    head_n        = head;
    lat_n         = lat;
    in_ready      = 1'b0;
    wr_en         = 1'b0;
    wr_zero       = 1'b0;
    wr_addr       = '0;
    current_count = '0;
    acc_clear     = 1'b0;
    acc_en        = 1'b0;
    out_valid     = 1'b0;
    busy          = 1'b1;
    unique case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_zero = 1'b1;
        wr_addr = cnt;
        if (cnt == LAST) begin
          cnt_n   = '0;
          head_n  = LAST;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        wr_addr  = head_inc;
        if (in_valid) begin
          wr_en   = 1'b1;
          head_n  = head_inc;
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        current_count = cnt;
        acc_en        = 1'b1;
        acc_clear     = (cnt == '0);
        if (cnt == LAST) begin
          cnt_n   = '0;
          lat_n   = '0;
          state_n = (MAC_LATENCY == 0) ? DONE : DRAIN;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (lat == LAT_LAST) state_n = DONE;
        else                 lat_n   = lat + 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = CLEAR;
    endcase
  end

endmodule
